data_mem_lsu: RTL

Load/store unit for the RISC-V core, sitting directly downstream of the stage-2 pipeline register (`reg_block_2`). It takes the registered effective address, store data, access size and signedness, issues a single-outstanding request on the data-memory bus with a req/ack handshake, and stalls the pipeline while the access is in flight. For loads, it byte-lane-aligns and sign/zero-extends the returned word and presents it with a write-enable pulse for the register-file write-back path. It also flags misaligned accesses and bus timeouts.

---
 rtl/data_mem_lsu.sv | 114 +++++++++++
 1 files changed

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: single-outstanding load/store unit with req/ack data bus, pipeline stall,
// load alignment/extension, register-file write-back strobe, misalign and timeout flags.
module data_mem_lsu #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        mem_rd_req_in,
    input  logic        mem_wr_req_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [1:0]  size_in,
    input  logic        load_unsigned_in,
    input  logic [4:0]  rd_addr_in,
    input  logic        rf_wr_en_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_wmask_out,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        wb_en_out,
    output logic [4:0]  wb_rd_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state, state_nx;
    logic [31:0] addr_q, wdata_q, wdata_fmt, ld_fmt;
    logic [3:0]  wmask_q, wmask_fmt;
    logic [1:0]  size_q;
    logic [4:0]  rd_q;
    logic [15:0] cnt;
    logic [15:0] lh;
    logic [7:0]  lb;
    logic        uns_q, we_q, rfwe_q, req, mis, mis_req, accept, busy, tmo;

    always_comb begin
        req       = mem_rd_req_in | mem_wr_req_in;
        mis       = (size_in == 2'b01 & addr_in[0]) | (size_in[1] & |addr_in[1:0]);
        mis_req   = state == IDLE && req && mis;
        accept    = state == IDLE && req && !mis;
        busy      = state == BUSY;
        tmo       = busy && !dmem_ack_in && cnt == 16'(TIMEOUT - 1);
        wdata_fmt = size_in == 2'b00 ? {4{store_data_in[7:0]}} :
                    size_in == 2'b01 ? {2{store_data_in[15:0]}} : store_data_in;
        wmask_fmt = size_in == 2'b00 ? 4'b0001 << addr_in[1:0] :
                    size_in == 2'b01 ? 4'b0011 << addr_in[1:0] : 4'b1111;
        lb        = dmem_rdata_in[{addr_q[1:0], 3'b000} +: 8];
        lh        = addr_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        ld_fmt    = size_q == 2'b00 ? {{24{~uns_q & lb[7]}}, lb} :
                    size_q == 2'b01 ? {{16{~uns_q & lh[15]}}, lh} : dmem_rdata_in;
    end

    always_comb begin
        state_nx = state == IDLE ? (accept ? BUSY : IDLE) : (dmem_ack_in || tmo ? IDLE : BUSY);
    end

    always_comb begin
        dmem_req_out   = busy;
        dmem_we_out    = busy & we_q;
        dmem_addr_out  = busy ? {addr_q[31:2], 2'b00} : '0;
        dmem_wdata_out = busy ? wdata_q : '0;
        dmem_wmask_out = busy ? wmask_q : '0;
        stall_out      = accept | (busy & ~dmem_ack_in & ~tmo);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            cnt            <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            size_q         <= '0;
            rd_q           <= '0;
            uns_q          <= 1'b0;
            we_q           <= 1'b0;
            rfwe_q         <= 1'b0;
            load_data_out  <= '0;
            wb_en_out      <= 1'b0;
            wb_rd_out      <= '0;
            misaligned_out <= 1'b0;
            bus_err_out    <= 1'b0;
        end else begin
            state          <= state_nx;
            wb_en_out      <= 1'b0;
            misaligned_out <= mis_req;
            bus_err_out    <= tmo;
            if (accept) begin
                addr_q  <= addr_in;
                size_q  <= size_in;
                uns_q   <= load_unsigned_in;
                rd_q    <= rd_addr_in;
                rfwe_q  <= rf_wr_en_in;
                we_q    <= mem_wr_req_in;
                wdata_q <= wdata_fmt;
                wmask_q <= mem_wr_req_in ? wmask_fmt : 4'b0000;
                cnt     <= '0;
            end else if (busy && !dmem_ack_in) begin
                cnt <= cnt + 16'd1;
            end
            // Stores leave the previous load result untouched
            if (busy && dmem_ack_in && !we_q) begin
                load_data_out <= ld_fmt;
                wb_en_out     <= rfwe_q & |rd_q;
                wb_rd_out     <= rd_q;
            end
        end
    end
endmodule
